// File: rtl/exec_unit_mc.sv
// Execution unit: ADD/SUB/AND in one cycle, iterative shift-add MUL, operand
// forwarding, NZCV flags and a valid/ready output register with flush.
module exec_unit_mc #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int N_SRC      = 3,
  parameter int N_FWD      = 2,
  parameter int MUL_CYCLES = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [1:0]                  op_i,
  input  logic                        update_flag_i,
  input  logic [N_SRC*ADDR_WIDTH-1:0] src_addr_i,
  input  logic [N_SRC*WIDTH-1:0]      src_data_i,
  input  logic [N_FWD-1:0]            fwd_en_i,
  input  logic [N_FWD*ADDR_WIDTH-1:0] fwd_addr_i,
  input  logic [N_FWD*WIDTH-1:0]      fwd_data_i,
  input  logic                        flush_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [WIDTH-1:0]            result_o,
  output logic [WIDTH-1:0]            store_data_o,
  output logic [3:0]                  flags_o
);

  localparam int STEP = WIDTH / MUL_CYCLES;
  localparam int CW   = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_MUL = 2'b11} op_t;

  state_t           r_state, w_state_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result, r_store;
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, r_st_pend;
  logic [CW-1:0]    r_cnt;
  logic             r_upd;

  op_t              w_op;
  logic [WIDTH-1:0] w_opnd [N_SRC];
  logic [WIDTH-1:0] w_a, w_b;
  logic [WIDTH:0]   w_add, w_sub;
  logic [WIDTH-1:0] w_alu_res, w_mul_sum;
  logic             w_alu_c, w_alu_v;
  logic             w_accept, w_mul_done;

  assign w_op = op_t'(op_i);

  // Youngest forward wins: scan from the oldest so lower indices overwrite.
  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      w_opnd[i] = src_data_i[i*WIDTH +: WIDTH];
      for (int unsigned j = N_FWD; j > 0; j--) begin
        if (fwd_en_i[j-1] &&
            fwd_addr_i[(j-1)*ADDR_WIDTH +: ADDR_WIDTH] == src_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH])
          w_opnd[i] = fwd_data_i[(j-1)*WIDTH +: WIDTH];
      end
    end
  end

  assign w_a   = w_opnd[0];
  assign w_b   = w_opnd[1];
  assign w_add = {1'b0, w_a} + {1'b0, w_b};
  assign w_sub = {1'b0, w_a} + {1'b0, ~w_b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = r_flags[1];
    w_alu_v   = r_flags[0];
    case (w_op)
      OP_ADD: begin
        {w_alu_c, w_alu_res} = w_add;
        w_alu_v = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_add[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB: begin
        {w_alu_c, w_alu_res} = w_sub;
        w_alu_v = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_sub[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_AND:  w_alu_res = w_a & w_b;
      default: w_alu_res = '0;
    endcase
  end

  // One multiply step consumes STEP multiplier bits against the shifted multiplicand.
  always_comb begin
    w_mul_sum = r_acc;
    for (int unsigned k = 0; k < STEP; k++) begin
      if (r_mplier[k])
        w_mul_sum = w_mul_sum + (r_mcand << k);
    end
  end

  assign in_ready_o = reset_i && (r_state == S_IDLE) && (!r_out_valid || out_ready_i);
  assign w_accept   = in_valid_i && in_ready_o && !flush_i;
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == CW'(MUL_CYCLES - 1));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept && w_op == OP_MUL) w_state_nxt = S_MUL;
        S_MUL:  if (w_mul_done) w_state_nxt = out_ready_i ? S_IDLE : S_HOLD;
        S_HOLD: if (out_ready_i) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_store     <= '0;
      r_flags     <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_st_pend   <= '0;
      r_cnt       <= '0;
      r_upd       <= 1'b0;
    end else begin
      if (flush_i) begin
        r_out_valid <= 1'b0;
      end else if (w_accept && w_op != OP_MUL) begin
        r_out_valid <= 1'b1;
        r_result    <= w_alu_res;
        r_store     <= w_opnd[N_SRC-1];
        if (update_flag_i)
          r_flags <= {w_alu_res[WIDTH-1], (w_alu_res == '0), w_alu_c, w_alu_v};
      end else if (w_mul_done) begin
        r_out_valid <= 1'b1;
        r_result    <= w_mul_sum;
        r_store     <= r_st_pend;
        if (r_upd)
          r_flags <= {w_mul_sum[WIDTH-1], (w_mul_sum == '0), r_flags[1:0]};
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end

      if (flush_i) begin
        r_cnt <= '0;
      end else if (w_accept && w_op == OP_MUL) begin
        r_mcand   <= w_a;
        r_mplier  <= w_b;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_st_pend <= w_opnd[N_SRC-1];
        r_upd     <= update_flag_i;
      end else if (r_state == S_MUL) begin
        r_mcand  <= r_mcand << STEP;
        r_mplier <= r_mplier >> STEP;
        r_acc    <= w_mul_sum;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign out_valid_o  = r_out_valid;
  assign result_o     = r_result;
  assign store_data_o = r_store;
  assign flags_o      = r_flags;

endmodule
